car_alarm_input_conditioner: RTL

//   Front-end stage for Car_Alarm_System_S. Synchronises and debounces the five raw switch/door inputs.

---
 rtl/car_alarm_input_conditioner_pkg.sv | 16 +
 rtl/car_alarm_input_conditioner_debounce_channel.sv | 57 +++++
 rtl/car_alarm_input_conditioner.sv | 123 ++++++++++++
 3 files changed

// File: rtl/car_alarm_input_conditioner_pkg.sv
// Shared constants for the car alarm input conditioner: channel count, channel indices
// and glitch counter width. The optional counter is enabled with CAS_GLITCH_COUNT_EN.
package car_alarm_pkg;

  localparam int NUM_SW    = 5;
  localparam int SW_BRAKE  = 0;
  localparam int SW_HIDDEN = 1;
  localparam int SW_IGN    = 2;
  localparam int SW_DDOOR  = 3;
  localparam int SW_PDOOR  = 4;

  localparam int GLITCH_W  = 8;

  typedef logic [NUM_SW-1:0] sw_vec_t;

endpackage

// File: rtl/car_alarm_input_conditioner_debounce_channel.sv
// One switch channel: synchroniser chain, debounce counter and clean level register.
// Reports a one-cycle update strobe when clean changes and an abort strobe on a cancelled debounce.
module cas_debounce_channel #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic clean_o,
  output logic update_o,
  output logic abort_o
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   clean_q, clean_d;
  logic                   sync;

  assign sync    = sync_q[SYNC_STAGES-1];
  assign clean_o = clean_q;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], raw_i};
    cnt_d    = cnt_q;
    clean_d  = clean_q;
    update_o = 1'b0;
    abort_o  = 1'b0;
    if (sync == clean_q) begin
      // Synced level fell back to clean before the count completed: debounce aborted.
      cnt_d   = '0;
      abort_o = (cnt_q != '0);
    end else if (cnt_q == CNT_LAST) begin
      clean_d  = sync;
      cnt_d    = '0;
      update_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
    end
  end

endmodule

// File: rtl/car_alarm_input_conditioner.sv
// Front end of the car alarm: debounces five raw switch inputs and derives door/ignition event pulses.
// Define CAS_GLITCH_COUNT_EN to add the saturating Glitch_count output of aborted debounces.
module car_alarm_input_conditioner
  import car_alarm_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic Clk,
  input  logic System_reset_n,
  input  logic Brake_depressed_raw,
  input  logic Hidden_switch_raw,
  input  logic Ignition_switch_raw,
  input  logic Driver_door_raw,
  input  logic Passenger_door_raw,
  output logic Brake_depressed_switch,
  output logic Hidden_switch,
  output logic Ignition_switch,
  output logic Driver_door,
  output logic Passenger_door,
  output logic Any_door_open,
  output logic Door_open_pulse,
  output logic Ignition_on_pulse,
  output logic Ignition_off_pulse
`ifdef CAS_GLITCH_COUNT_EN
  ,
  output logic [GLITCH_W-1:0] Glitch_count
`endif
);

  sw_vec_t raw_vec;
  sw_vec_t clean;
  sw_vec_t update;
  sw_vec_t abort;

  assign raw_vec[SW_BRAKE]  = Brake_depressed_raw;
  assign raw_vec[SW_HIDDEN] = Hidden_switch_raw;
  assign raw_vec[SW_IGN]    = Ignition_switch_raw;
  assign raw_vec[SW_DDOOR]  = Driver_door_raw;
  assign raw_vec[SW_PDOOR]  = Passenger_door_raw;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_chan
    cas_debounce_channel #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (Clk),
      .rst_n    (System_reset_n),
      .raw_i    (raw_vec[g]),
      .clean_o  (clean[g]),
      .update_o (update[g]),
      .abort_o  (abort[g])
    );
  end

  assign Brake_depressed_switch = clean[SW_BRAKE];
  assign Hidden_switch          = clean[SW_HIDDEN];
  assign Ignition_switch        = clean[SW_IGN];
  assign Driver_door            = clean[SW_DDOOR];
  assign Passenger_door         = clean[SW_PDOOR];
  assign Any_door_open          = clean[SW_DDOOR] | clean[SW_PDOOR];

  logic door_pulse_q, door_pulse_d;
  logic ign_on_q, ign_on_d;
  logic ign_off_q, ign_off_d;

  // An update strobe with clean currently low is a rising edge; pulses register on the
  // same edge that moves clean, so they appear in the first cycle of the new level.
  always_comb begin
    door_pulse_d = (update[SW_DDOOR] & ~clean[SW_DDOOR]) |
                   (update[SW_PDOOR] & ~clean[SW_PDOOR]);
    ign_on_d     = update[SW_IGN] & ~clean[SW_IGN];
    ign_off_d    = update[SW_IGN] &  clean[SW_IGN];
  end

  always_ff @(posedge Clk or negedge System_reset_n) begin
    if (!System_reset_n) begin
      door_pulse_q <= 1'b0;
      ign_on_q     <= 1'b0;
      ign_off_q    <= 1'b0;
    end else begin
      door_pulse_q <= door_pulse_d;
      ign_on_q     <= ign_on_d;
      ign_off_q    <= ign_off_d;
    end
  end

  assign Door_open_pulse    = door_pulse_q;
  assign Ignition_on_pulse  = ign_on_q;
  assign Ignition_off_pulse = ign_off_q;

`ifdef CAS_GLITCH_COUNT_EN
  localparam int ABORT_W = $clog2(NUM_SW + 1);

  logic [GLITCH_W-1:0] glitch_q, glitch_d;
  logic [GLITCH_W:0]   glitch_sum;
  logic [ABORT_W-1:0]  abort_cnt;

  // Several channels aborting on one edge each add one; the extra top bit flags overflow.
  always_comb begin
    abort_cnt = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      abort_cnt = abort_cnt + {{(ABORT_W-1){1'b0}}, abort[i]};
    end
    glitch_sum = {1'b0, glitch_q} + {{(GLITCH_W+1-ABORT_W){1'b0}}, abort_cnt};
    glitch_d   = glitch_sum[GLITCH_W] ? {GLITCH_W{1'b1}} : glitch_sum[GLITCH_W-1:0];
  end

  always_ff @(posedge Clk or negedge System_reset_n) begin
    if (!System_reset_n) begin
      glitch_q <= '0;
    end else begin
      glitch_q <= glitch_d;
    end
  end

  assign Glitch_count = glitch_q;
`else
  logic unused_abort;
  assign unused_abort = ^abort;
`endif

endmodule
